// File: rtl/issue_unit_pkg.sv
// Shared types and constants for the dispatch stage: instruction type codes,
// the queued instruction record and the resolved-operand pair.
package issue_unit_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam logic [XLEN-1:0] TAG_NONE = 32'hFFFF_FFFF;

    typedef enum logic [5:0] {
        T_LUI, T_AUIPC, T_JAL, T_JALR,
        T_BEQ, T_BNE, T_BLT, T_BGE, T_BLTU, T_BGEU,
        T_LB, T_LH, T_LW, T_LBU, T_LHU,
        T_SB, T_SH, T_SW,
        T_ADDI, T_SLTI, T_SLTIU, T_XORI, T_ORI, T_ANDI, T_SLLI, T_SRLI, T_SRAI,
        T_ADD, T_SUB, T_SLL, T_SLT, T_SLTU, T_XOR, T_SRL, T_SRA, T_OR, T_AND
    } instr_type_e;

    typedef struct packed {
        instr_type_e     itype;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            is_mem;
    } iq_entry_t;

    // v is meaningful only when q == TAG_NONE
    typedef struct packed {
        logic [XLEN-1:0] v;
        logic [XLEN-1:0] q;
    } opnd_t;

endpackage

// File: rtl/issue_fifo.sv
// In-order instruction queue: circular buffer with head/tail pointers and an
// occupancy count. 'en' low freezes everything; flush empties the queue.
module issue_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic          push_ok, pop_ok;

    assign push_ok = push && (count_q != FULL_CNT);
    assign pop_ok  = pop && (count_q != '0);
    assign dout    = mem_q[head_q];
    assign count   = count_q;
    assign empty   = (count_q == '0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (en) begin
            if (flush) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (push_ok) begin
                    mem_d[tail_q] = din;
                    tail_d        = tail_q + 1'b1;
                end
                if (pop_ok) begin
                    head_d = head_q + 1'b1;
                end
                case ({push_ok, pop_ok})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is not reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/issue_unit.sv
// Dispatch stage: queues decoded instructions, renames operands through the
// register status table and issues into RS/SLB with a ROB allocation.
// ISSUE_BYPASS_EN: enables same-cycle CDB forwarding; without it, issue stalls
// one cycle when the CDB broadcasts a tag the head is still waiting on.
module issue_unit
    import issue_unit_pkg::*;
#(
    parameter int QDEPTH = 16,
    parameter int RS_W   = 5,
    parameter int ROB_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_type,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic              in_is_mem,
    output logic [4:0]        rf_addr1,
    output logic [4:0]        rf_addr2,
    input  logic [XLEN-1:0]   rf_data1,
    input  logic [XLEN-1:0]   rf_data2,
    input  logic              rob_full,
    input  logic [ROB_W-1:0]  rob_tail,
    output logic              rob_alloc,
    output logic [ROB_W-1:0]  rob_qtag1,
    output logic [ROB_W-1:0]  rob_qtag2,
    input  logic              rob_rdy1,
    input  logic              rob_rdy2,
    input  logic [XLEN-1:0]   rob_val1,
    input  logic [XLEN-1:0]   rob_val2,
    input  logic              commit_valid,
    input  logic [4:0]        commit_rd,
    input  logic [ROB_W-1:0]  commit_tag,
    input  logic              cdb_valid,
    input  logic [ROB_W-1:0]  cdb_tag,
    input  logic [XLEN-1:0]   cdb_value,
    input  logic [RS_W-1:0]   rs_free_pos,
    input  logic              slb_full,
    output logic              rs_we,
    output logic              slb_we,
    output logic [RS_W-1:0]   rs_pos,
    output logic [XLEN-1:0]   is_vj,
    output logic [XLEN-1:0]   is_vk,
    output logic [XLEN-1:0]   is_qj,
    output logic [XLEN-1:0]   is_qk,
    output logic [5:0]        is_type,
    output logic [XLEN-1:0]   is_pc,
    output logic [XLEN-1:0]   is_A,
    output logic [XLEN-1:0]   is_reorder
);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] QDEPTH_CNT = QDEPTH[CW-1:0];

    iq_entry_t          in_entry, head_raw, head;
    logic [CW-1:0]      q_count;
    logic               q_empty, head_vld;
    logic               push, issue, room, stall;
    logic               busy1, busy2;
    logic [ROB_W-1:0]   tag1, tag2;
    opnd_t              op1, op2;

    logic [NREG-1:0]    busy_q, busy_d;
    logic [ROB_W-1:0]   tag_q [NREG];
    logic [ROB_W-1:0]   tag_d [NREG];

    function automatic opnd_t resolve(
        input logic [4:0]       rs,
        input logic             busy,
        input logic [ROB_W-1:0] tag,
        input logic [XLEN-1:0]  rf,
        input logic             rrdy,
        input logic [XLEN-1:0]  rval,
        input logic             cv,
        input logic [ROB_W-1:0] ct,
        input logic [XLEN-1:0]  cval
    );
        opnd_t o;
        o.v = '0;
        o.q = TAG_NONE;
        if (rs == 5'd0) begin
            o.v = '0;
        end else if (!busy) begin
            o.v = rf;
        end else if (rrdy) begin
            o.v = rval;
`ifdef ISSUE_BYPASS_EN
        end else if (cv && (ct == tag)) begin
            o.v = cval;
`endif
        end else begin
            o.q = {{(XLEN-ROB_W){1'b0}}, tag};
        end
        return o;
    endfunction

    always_comb begin
        in_entry        = '0;
        in_entry.itype  = instr_type_e'(in_type);
        in_entry.pc     = in_pc;
        in_entry.imm    = in_imm;
        in_entry.rd     = in_rd;
        in_entry.rs1    = in_rs1;
        in_entry.rs2    = in_rs2;
        in_entry.is_mem = in_is_mem;
    end

    assign in_ready = (q_count < QDEPTH_CNT);
    assign push     = in_valid && in_ready && !clear;

    issue_fifo #(
        .DEPTH (QDEPTH),
        .W     ($bits(iq_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .en    (rdy),
        .flush (clear),
        .push  (push),
        .pop   (issue),
        .din   (in_entry),
        .dout  (head_raw),
        .count (q_count),
        .empty (q_empty)
    );

    // An empty queue presents an all-zero head so the payload idles at reset values.
    assign head_vld = !q_empty;
    assign head     = head_vld ? head_raw : '0;

    assign rf_addr1  = head.rs1;
    assign rf_addr2  = head.rs2;
    assign busy1     = busy_q[head.rs1];
    assign busy2     = busy_q[head.rs2];
    assign tag1      = tag_q[head.rs1];
    assign tag2      = tag_q[head.rs2];
    assign rob_qtag1 = tag1;
    assign rob_qtag2 = tag2;

    assign op1 = resolve(head.rs1, busy1, tag1, rf_data1, rob_rdy1, rob_val1,
                         cdb_valid, cdb_tag, cdb_value);
    assign op2 = resolve(head.rs2, busy2, tag2, rf_data2, rob_rdy2, rob_val2,
                         cdb_valid, cdb_tag, cdb_value);

`ifdef ISSUE_BYPASS_EN
    assign stall = 1'b0;
`else
    // Without forwarding the broadcast would be lost to an entry written this cycle.
    assign stall = cdb_valid &&
                   (((head.rs1 != 5'd0) && busy1 && !rob_rdy1 && (cdb_tag == tag1)) ||
                    ((head.rs2 != 5'd0) && busy2 && !rob_rdy2 && (cdb_tag == tag2)));
`endif

    assign room  = head.is_mem ? !slb_full : (rs_free_pos != '1);
    assign issue = rdy && !clear && head_vld && !rob_full && room && !stall;

    assign rob_alloc  = issue;
    assign rs_we      = issue && !head.is_mem;
    assign slb_we     = issue && head.is_mem;
    assign rs_pos     = rs_free_pos;
    assign is_vj      = op1.v;
    assign is_qj      = op1.q;
    assign is_vk      = op2.v;
    assign is_qk      = op2.q;
    assign is_type    = head.itype;
    assign is_pc      = head.pc;
    assign is_A       = head.imm;
    assign is_reorder = head_vld ? {{(XLEN-ROB_W){1'b0}}, rob_tail} : '0;

    // Commit is applied before issue so a new writer of the same rd wins.
    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        if (rdy) begin
            if (clear) begin
                busy_d = '0;
            end else begin
                if (commit_valid && (tag_q[commit_rd] == commit_tag)) begin
                    busy_d[commit_rd] = 1'b0;
                end
                if (issue && (head.rd != 5'd0)) begin
                    busy_d[head.rd] = 1'b1;
                    tag_d[head.rd]  = rob_tail;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

endmodule

// File: tb/tb_issue_unit.sv
// Directed table-driven bench for issue_unit: each record is one cycle of
// stimulus plus the combinational outputs expected before that cycle's edge.
module tb_issue_unit;
    import issue_unit_pkg::*;

    logic        clk, rst, rdy, clear, in_valid, in_ready, in_is_mem;
    logic [5:0]  in_type;
    logic [31:0] in_pc, in_imm, rf_data1, rf_data2, rob_val1, rob_val2, cdb_value;
    logic [4:0]  in_rd, in_rs1, in_rs2, rf_addr1, rf_addr2, commit_rd, rs_free_pos, rs_pos;
    logic        rob_full, rob_alloc, rob_rdy1, rob_rdy2, commit_valid, cdb_valid, slb_full;
    logic [3:0]  rob_tail, rob_qtag1, rob_qtag2, commit_tag, cdb_tag;
    logic        rs_we, slb_we;
    logic [31:0] is_vj, is_vk, is_qj, is_qk, is_pc, is_A, is_reorder;
    logic [5:0]  is_type;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [31:0] N = 32'hFFFF_FFFF;

    issue_unit dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
        .in_pc(in_pc), .in_imm(in_imm), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_is_mem(in_is_mem), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .rob_full(rob_full), .rob_tail(rob_tail),
        .rob_alloc(rob_alloc), .rob_qtag1(rob_qtag1), .rob_qtag2(rob_qtag2),
        .rob_rdy1(rob_rdy1), .rob_rdy2(rob_rdy2), .rob_val1(rob_val1), .rob_val2(rob_val2),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .rs_free_pos(rs_free_pos), .slb_full(slb_full), .rs_we(rs_we), .slb_we(slb_we),
        .rs_pos(rs_pos), .is_vj(is_vj), .is_vk(is_vk), .is_qj(is_qj), .is_qk(is_qk),
        .is_type(is_type), .is_pc(is_pc), .is_A(is_A), .is_reorder(is_reorder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy, clear, in_valid, is_mem;
        logic [5:0]  ty;
        logic [31:0] pc, imm;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] rf1, rf2, rv1, rv2, dval;
        logic        rob_full, rr1, rr2, cv, dv, slb_full;
        logic [3:0]  rob_tail, ctag, dtag;
        logic [4:0]  crd, free;
        logic        e_ready, e_rs, e_slb, e_alloc;
        logic [4:0]  e_ra1, e_ra2;
        logic [5:0]  e_type;
        logic [31:0] e_pc, e_A, e_vj, e_qj, e_vk, e_qk, e_reorder;
    } vec_t;

    function automatic vec_t idle();
        vec_t v;
        v.rdy = 1'b1; v.clear = 1'b0; v.in_valid = 1'b0; v.is_mem = 1'b0;
        v.ty = 6'd0; v.pc = 32'd0; v.imm = 32'd0; v.rd = 5'd0; v.rs1 = 5'd0; v.rs2 = 5'd0;
        v.rf1 = 32'd0; v.rf2 = 32'd0; v.rv1 = 32'd0; v.rv2 = 32'd0; v.dval = 32'd0;
        v.rob_full = 1'b0; v.rr1 = 1'b0; v.rr2 = 1'b0; v.cv = 1'b0; v.dv = 1'b0;
        v.slb_full = 1'b0; v.rob_tail = 4'd0; v.ctag = 4'd0; v.dtag = 4'd0;
        v.crd = 5'd0; v.free = 5'd3;
        v.e_ready = 1'b1; v.e_rs = 1'b0; v.e_slb = 1'b0; v.e_alloc = 1'b0;
        v.e_ra1 = 5'd0; v.e_ra2 = 5'd0; v.e_type = 6'd0; v.e_pc = 32'd0; v.e_A = 32'd0;
        v.e_vj = 32'd0; v.e_qj = N; v.e_vk = 32'd0; v.e_qk = N; v.e_reorder = 32'd0;
        return v;
    endfunction

    function automatic vec_t push(vec_t vi, instr_type_e t, logic [4:0] rd, logic [4:0] rs1,
                                  logic [4:0] rs2, logic [31:0] imm, logic [31:0] pc, logic mem);
        vec_t v = vi;
        v.in_valid = 1'b1; v.ty = t; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.pc = pc; v.is_mem = mem;
        return v;
    endfunction

    function automatic vec_t head(vec_t vi, instr_type_e t, logic [4:0] ra1, logic [4:0] ra2,
                                  logic [31:0] vj, logic [31:0] qj, logic [31:0] vk,
                                  logic [31:0] qk, logic [31:0] a, logic [31:0] pc,
                                  logic [31:0] reorder);
        vec_t v = vi;
        v.e_type = t; v.e_ra1 = ra1; v.e_ra2 = ra2; v.e_vj = vj; v.e_qj = qj;
        v.e_vk = vk; v.e_qk = qk; v.e_A = a; v.e_pc = pc; v.e_reorder = reorder;
        return v;
    endfunction

    task automatic run(input vec_t v, input int id);
        logic [248:0] got, exp;
        @(negedge clk);
        rdy = v.rdy; clear = v.clear; in_valid = v.in_valid; in_type = v.ty;
        in_pc = v.pc; in_imm = v.imm; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
        in_is_mem = v.is_mem; rf_data1 = v.rf1; rf_data2 = v.rf2;
        rob_full = v.rob_full; rob_tail = v.rob_tail; rob_rdy1 = v.rr1; rob_rdy2 = v.rr2;
        rob_val1 = v.rv1; rob_val2 = v.rv2; commit_valid = v.cv; commit_rd = v.crd;
        commit_tag = v.ctag; cdb_valid = v.dv; cdb_tag = v.dtag; cdb_value = v.dval;
        rs_free_pos = v.free; slb_full = v.slb_full;
        #1;
        got = {in_ready, rs_we, slb_we, rob_alloc, rs_pos, rf_addr1, rf_addr2, is_type,
               is_pc, is_A, is_vj, is_qj, is_vk, is_qk, is_reorder};
        exp = {v.e_ready, v.e_rs, v.e_slb, v.e_alloc, v.free, v.e_ra1, v.e_ra2, v.e_type,
               v.e_pc, v.e_A, v.e_vj, v.e_qj, v.e_vk, v.e_qk, v.e_reorder};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL vec%0d rdy/rs/slb/alloc got=%b%b%b%b exp=%b%b%b%b", id,
                     in_ready, rs_we, slb_we, rob_alloc, v.e_ready, v.e_rs, v.e_slb, v.e_alloc);
            $display("  vec%0d got pos=%0d ra=%0d,%0d ty=%0d pc=%h A=%h vj=%h qj=%h vk=%h qk=%h rob=%h",
                     id, rs_pos, rf_addr1, rf_addr2, is_type, is_pc, is_A, is_vj, is_qj,
                     is_vk, is_qk, is_reorder);
            $display("  vec%0d exp pos=%0d ra=%0d,%0d ty=%0d pc=%h A=%h vj=%h qj=%h vk=%h qk=%h rob=%h",
                     id, v.free, v.e_ra1, v.e_ra2, v.e_type, v.e_pc, v.e_A, v.e_vj, v.e_qj,
                     v.e_vk, v.e_qk, v.e_reorder);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[$];
        vec_t v;

        // ADDI x1,x0,5 then dependent ADD x2,x1,x1 back-to-back
        tbl.push_back(idle());
        v = push(idle(), T_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h100, 1'b0); v.rob_tail = 4'd2;
        tbl.push_back(v);
        v = push(idle(), T_ADD, 5'd2, 5'd1, 5'd1, 32'd0, 32'h104, 1'b0); v.rob_tail = 4'd2;
        v = head(v, T_ADDI, 5'd0, 5'd0, 32'd0, N, 32'd0, N, 32'd5, 32'h100, 32'd2);
        v.e_rs = 1'b1; v.e_alloc = 1'b1; tbl.push_back(v);
        v = idle(); v.rob_tail = 4'd3;
        v = head(v, T_ADD, 5'd1, 5'd1, 32'd0, 32'd2, 32'd0, 32'd2, 32'd0, 32'h104, 32'd3);
        v.e_rs = 1'b1; v.e_alloc = 1'b1; tbl.push_back(v);

        // ADD x4,x1,x0 with a CDB broadcast of tag 2 in its first head cycle
        v = push(idle(), T_ADD, 5'd4, 5'd1, 5'd0, 32'd0, 32'h108, 1'b0); v.rob_tail = 4'd4;
        tbl.push_back(v);
        v = idle(); v.rob_tail = 4'd4; v.dv = 1'b1; v.dtag = 4'd2; v.dval = 32'd7;
`ifdef ISSUE_BYPASS_EN
        v = head(v, T_ADD, 5'd1, 5'd0, 32'd7, N, 32'd0, N, 32'd0, 32'h108, 32'd4);
        v.e_rs = 1'b1; v.e_alloc = 1'b1;
`else
        v = head(v, T_ADD, 5'd1, 5'd0, 32'd0, 32'd2, 32'd0, N, 32'd0, 32'h108, 32'd4);
`endif
        tbl.push_back(v);
        v = idle(); v.rob_tail = 4'd4; v.rr1 = 1'b1; v.rv1 = 32'd7;
`ifndef ISSUE_BYPASS_EN
        v = head(v, T_ADD, 5'd1, 5'd0, 32'd7, N, 32'd0, N, 32'd0, 32'h108, 32'd4);
        v.e_rs = 1'b1; v.e_alloc = 1'b1;
`endif
        tbl.push_back(v);

        // LW x5,8(x0) blocked by a full SLB for three cycles
        v = push(idle(), T_LW, 5'd5, 5'd0, 5'd0, 32'd8, 32'h10c, 1'b1); v.rob_tail = 4'd5;
        tbl.push_back(v);
        for (int k = 0; k < 4; k++) begin
            v = idle(); v.rob_tail = 4'd5; v.slb_full = (k < 3);
            v = head(v, T_LW, 5'd0, 5'd0, 32'd0, N, 32'd0, N, 32'd8, 32'h10c, 32'd5);
            v.e_slb = (k == 3); v.e_alloc = (k == 3);
            tbl.push_back(v);
        end

        // Commit of x1/tag2 races the issue of a new x1 writer with tag 5
        v = push(idle(), T_ADDI, 5'd1, 5'd0, 5'd0, 32'd1, 32'h110, 1'b0); v.rob_tail = 4'd5;
        tbl.push_back(v);
        v = push(idle(), T_ADD, 5'd6, 5'd1, 5'd0, 32'd0, 32'h114, 1'b0); v.rob_tail = 4'd5;
        v.cv = 1'b1; v.crd = 5'd1; v.ctag = 4'd2;
        v = head(v, T_ADDI, 5'd0, 5'd0, 32'd0, N, 32'd0, N, 32'd1, 32'h110, 32'd5);
        v.e_rs = 1'b1; v.e_alloc = 1'b1; tbl.push_back(v);
        v = idle(); v.rob_tail = 4'd6;
        v = head(v, T_ADD, 5'd1, 5'd0, 32'd0, 32'd5, 32'd0, N, 32'd0, 32'h114, 32'd6);
        v.e_rs = 1'b1; v.e_alloc = 1'b1; tbl.push_back(v);

        // Matching commit frees x2; x4 still waits on tag 4
        v = push(idle(), T_ADD, 5'd7, 5'd2, 5'd4, 32'd0, 32'h118, 1'b0);
        v.cv = 1'b1; v.crd = 5'd2; v.ctag = 4'd3; v.rf1 = 32'h11; v.rf2 = 32'h22;
        tbl.push_back(v);
        v = idle(); v.rob_tail = 4'd7; v.rf1 = 32'h11; v.rf2 = 32'h22;
        v = head(v, T_ADD, 5'd2, 5'd4, 32'h11, N, 32'd0, 32'd4, 32'd0, 32'h118, 32'd7);
        v.e_rs = 1'b1; v.e_alloc = 1'b1; tbl.push_back(v);

        // rdy low: push ignored, then head held without write enables
        v = push(idle(), T_ADDI, 5'd8, 5'd0, 5'd0, 32'd9, 32'h11c, 1'b0); v.rdy = 1'b0;
        tbl.push_back(v);
        tbl.push_back(idle());
        v = push(idle(), T_ADDI, 5'd9, 5'd0, 5'd0, 32'd9, 32'h120, 1'b0); v.rob_tail = 4'd8;
        tbl.push_back(v);
        v = idle(); v.rdy = 1'b0; v.rob_tail = 4'd8;
        v = head(v, T_ADDI, 5'd0, 5'd0, 32'd0, N, 32'd0, N, 32'd9, 32'h120, 32'd8);
        tbl.push_back(v);
        v.rdy = 1'b1; v.e_rs = 1'b1; v.e_alloc = 1'b1; tbl.push_back(v);

        rst = 1'b1;
        v = idle();
        run(v, -1);
        n_vec = 0;
        n_bad = 0;
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) run(tbl[i], i);

        // Fill the queue while the ROB is full
        for (int i = 0; i < 16; i++) begin
            v = push(idle(), T_ADDI, 5'd0, 5'd0, 5'd0, 32'h20 + i, 32'h200 + 4 * i, 1'b0);
            v.rob_full = 1'b1; v.rob_tail = 4'd9;
            if (i > 0) v = head(v, T_ADDI, 5'd0, 5'd0, 32'd0, N, 32'd0, N, 32'h20, 32'h200, 32'd9);
            run(v, 100 + i);
        end
        v = push(idle(), T_ADDI, 5'd0, 5'd0, 5'd0, 32'h40, 32'h300, 1'b0);
        v.rob_full = 1'b1; v.rob_tail = 4'd9; v.e_ready = 1'b0;
        v = head(v, T_ADDI, 5'd0, 5'd0, 32'd0, N, 32'd0, N, 32'h20, 32'h200, 32'd9);
        run(v, 200);
        // Full queue: pop frees a slot but no push happens this edge
        v.rob_full = 1'b0; v.e_rs = 1'b1; v.e_alloc = 1'b1;
        run(v, 201);
        v = idle(); v.rob_full = 1'b1; v.rob_tail = 4'd9;
        v = head(v, T_ADDI, 5'd0, 5'd0, 32'd0, N, 32'd0, N, 32'h21, 32'h204, 32'd9);
        run(v, 202);
        v.rob_full = 1'b0; v.clear = 1'b1;
        run(v, 203);
        // After the flush: queue empty and x1/x9 no longer busy
        v = push(idle(), T_ADD, 5'd10, 5'd1, 5'd9, 32'd0, 32'h304, 1'b0);
        v.rf1 = 32'h33; v.rf2 = 32'h44;
        run(v, 204);
        v = idle(); v.rf1 = 32'h33; v.rf2 = 32'h44; v.rob_tail = 4'd9;
        v = head(v, T_ADD, 5'd1, 5'd9, 32'h33, N, 32'h44, N, 32'd0, 32'h304, 32'd9);
        v.e_rs = 1'b1; v.e_alloc = 1'b1;
        run(v, 205);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/issue_unit.md
# issue_unit

Dispatch stage between the decoder and the execution back end. It buffers decoded instructions in an in-order queue and renames operands through a register status table. Each instruction is issued into a free reservation-station slot (ALU, branch, jump) or into the store/load buffer (memory ops), and gets a ROB entry in the same cycle. It is the writer side of the RS/SLB dispatch interface and snoops the RS result broadcast and ROB commit.

## Interface
- QDEPTH, 16: instruction queue entries (power of 2)
- RS_W, 5: RS slot index width; all-ones = no free slot
- ROB_W, 4: ROB tag width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; low freezes all state, `rs_we`/`slb_we`/`rob_alloc` forced 0
- clear  in  1  misprediction flush
- in_valid / in_ready  in/out  1  decoder handshake; transfer when both high at posedge
- in_type  in  6  instruction type code (package enum)
- in_pc, in_imm  in  32  instruction pc, immediate
- in_rd, in_rs1, in_rs2  in  5  register indices; 0 = unused/x0
- in_is_mem  in  1  1 = route to SLB, 0 = route to RS
- rf_addr1, rf_addr2  out  5  register file read addresses = head rs1/rs2
- rf_data1, rf_data2  in  32  combinational register file read data
- rob_full  in  1  no free ROB entry
- rob_tail  in  ROB_W  tag the next allocation receives
- rob_alloc  out  1  allocate ROB entry this cycle
- rob_qtag1, rob_qtag2  out  ROB_W  tags probed for early readiness
- rob_rdy1, rob_rdy2  in  1  probed entry already holds its result
- rob_val1, rob_val2  in  32  probed entry value
- commit_valid, commit_rd, commit_tag  in  1/5/ROB_W  ROB retire of a register write
- cdb_valid, cdb_tag, cdb_value  in  1/ROB_W/32  RS result broadcast this cycle
- rs_free_pos  in  RS_W  lowest free RS slot
- slb_full  in  1  SLB cannot accept
- rs_we, slb_we  out  1  write the payload into RS slot `rs_pos` / SLB tail
- rs_pos  out  RS_W  = rs_free_pos
- is_vj, is_vk, is_qj, is_qk  out  32  operand values and tags; tag 32'hFFFF_FFFF = ready
- is_type, is_pc, is_A, is_reorder  out  6/32/32/32  type, pc, imm, zero-extended ROB tag

## Operation
- Queue: circular buffer with head/tail pointers plus a count; in_ready = count < QDEPTH. Push and pop can occur in the same cycle, including when the queue is full (pop frees the slot at that edge, but in_ready was already low, so no push).
- Issue condition: queue non-empty, !rob_full, and the target has room (RS: rs_free_pos != all-ones; SLB: !slb_full), and no bypass stall (see Configuration). On issue: pop, rob_alloc=1, is_reorder=rob_tail, and exactly one of rs_we/slb_we is asserted.
- Operand resolution (rs1 and rs2 independently):
  - index 0: value 0, ready;
  - register not busy: rf_data, ready;
  - busy with tag t, rob_rdy: rob_val, ready;
  - cdb_valid && cdb_tag==t: cdb_value, ready;
  - otherwise q = t, v = 0.
- Status table: 32 × {busy, tag}.
  - Issue with rd != 0: busy[rd]=1, tag[rd]=rob_tail.
  - Commit: clear busy[commit_rd] only if tag[commit_rd]==commit_tag.
  - Same-cycle issue and commit to the same rd: the issue wins.
- Clear (rdy high): queue emptied, all busy bits cleared, no issue that cycle; clear has priority over push and issue.
- Reset values: queue empty, all busy bits 0, all write enables 0, payload outputs 0, is_qj/is_qk all-ones.

## Timing
- Payload and write enables are combinational from the queue head and are consumed by RS/SLB/ROB at the same posedge.
- Latency: an instruction pushed at edge N is at the head after N and issues at edge N+1 at the earliest.
- Throughput: one issue per cycle.
- The status-table update is visible to the next head instruction in the following cycle, so back-to-back dependent instructions are renamed correctly.
- rdy low: no pointer or table change; in_ready is still reported.

## Configuration
- ISSUE_BYPASS_EN defined: the CDB tag match in operand resolution is enabled (same-cycle forwarding).
- ISSUE_BYPASS_EN undefined: no CDB forwarding. If cdb_valid and cdb_tag equals a busy source tag whose rob_rdy is low, issue stalls one cycle. This prevents a new entry from missing the broadcast.

## Structure
- Shared package:
  - instruction type enum (including JALR)
  - TAG_NONE = 32'hFFFF_FFFF
  - XLEN
  - register-count constant
- Sub-module `issue_fifo`: the parameterised queue with push/pop/flush, count and full/empty.
- Status table, operand resolution and issue control live in `issue_unit`.

## Test plan
- Reset, then push ADDI x1,x0,5 with rs_free_pos=3, rob_tail=2 -> the next cycle rs_we=1, rs_pos=3, is_vj=0, is_qj=all-ones, is_A=5, is_reorder=2; busy[1]=1 with tag 2.
- ADDI x1 then ADD x2,x1,x1 back-to-back with ROB not ready -> the ADD issues with is_qj=is_qk=2.
- Dependent ADD with cdb_valid, cdb_tag=2, cdb_value=7 in its issue cycle:
  - with the macro, is_vj=7 and q=all-ones;
  - without it, a one-cycle stall, then an issue using the ROB value.
- LW with slb_full=1 for 3 cycles -> no issue and no rob_alloc; slb_we on the 4th cycle.
- Fill 16 entries with rob_full=1 -> in_ready=0; a clear the next cycle -> queue empty, busy cleared, in_ready=1.
- commit of x1 tag 2 in the same cycle as the issue of a new writer of x1 with tag 5 -> busy[1] stays 1 and tag[1]=5.
